seg_decode_monitor: RTL and testbench

SEG_DECODE_MONITOR -- requirements
Module: seg_decode_monitor

---
 rtl/seg_decode_monitor.sv | 149 ++++++++++++++
 tb/tb_seg_decode_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decode_monitor.sv
// Seven-segment four-digit display monitor: debounces the segment pattern,
// decodes it to BCD/binary and checks that the displayed value steps by one.
module seg_decode_monitor #(
   parameter int STABLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_thous,
   input  logic [6:0]  seg_hunds,
   input  logic [6:0]  seg_tens,
   input  logic [6:0]  seg_units,
   output logic [15:0] digits,
   output logic [13:0] count,
   output logic        valid,
   output logic        update,
   output logic        clr_seen,
   output logic        step_err,
   output logic        pattern_err,
   output logic [15:0] step_cnt
);

   typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

   localparam logic [4:0] NEED = 5'(STABLE_CYCLES);

   state_t      state_q;
   logic [27:0] sample_q;
   logic [27:0] acc_q;
   logic        acc_seen_q;
   logic [3:0]  run_q;
   logic [3:0]  run_d;
   logic [15:0] digits_q;
   logic [13:0] count_q;
   logic        valid_q;
   logic        update_q;
   logic        clr_q;
   logic        serr_q;
   logic        perr_q;
   logic [15:0] step_cnt_q;

   logic [27:0] pat;
   logic        same;
   logic [4:0]  held;
   logic        accept;
   logic [4:0]  d3, d2, d1, d0;
   logic        all_ok;
   logic [13:0] val;
   logic [13:0] exp_v;

   // {ok, digit}; ok is clear for any non-numeral pattern
   function automatic logic [4:0] dec(input logic [6:0] s);
      unique case (s)
         7'h3F:   dec = 5'h10;
         7'h06:   dec = 5'h11;
         7'h5B:   dec = 5'h12;
         7'h4F:   dec = 5'h13;
         7'h66:   dec = 5'h14;
         7'h6D:   dec = 5'h15;
         7'h7D:   dec = 5'h16;
         7'h07:   dec = 5'h17;
         7'h7F:   dec = 5'h18;
         7'h6F:   dec = 5'h19;
         default: dec = 5'h00;
      endcase
   endfunction

   assign pat  = {seg_thous, seg_hunds, seg_tens, seg_units};
   assign same = (pat == sample_q);

   // number of consecutive edges, including this one, showing pat
   assign held   = same ? ({1'b0, run_q} + 5'd2) : 5'd1;
   assign accept = (held >= NEED) && (!acc_seen_q || (pat != acc_q));

   assign run_d = !same          ? 4'd0 :
                  (run_q == 4'hF) ? run_q : run_q + 4'd1;

   assign d3     = dec(seg_thous);
   assign d2     = dec(seg_hunds);
   assign d1     = dec(seg_tens);
   assign d0     = dec(seg_units);
   assign all_ok = d3[4] & d2[4] & d1[4] & d0[4];

   assign val = 14'(d3[3:0]) * 14'd1000 +
                14'(d2[3:0]) * 14'd100 +
                14'(d1[3:0]) * 14'd10 +
                14'(d0[3:0]);

   assign exp_v = (count_q == 14'd9999) ? 14'd0 : count_q + 14'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sample_q   <= '0;
         acc_q      <= '0;
         acc_seen_q <= 1'b0;
         run_q      <= '0;
         digits_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         update_q   <= 1'b0;
         clr_q      <= 1'b0;
         serr_q     <= 1'b0;
         perr_q     <= 1'b0;
         step_cnt_q <= '0;
      end else begin
         sample_q <= pat;
         run_q    <= run_d;
         update_q <= 1'b0;
         clr_q    <= 1'b0;
         serr_q   <= 1'b0;
         perr_q   <= 1'b0;
         if (accept) begin
            acc_q      <= pat;
            acc_seen_q <= 1'b1;
            if (!all_ok) begin
               perr_q  <= 1'b1;
               valid_q <= 1'b0;
               state_q <= ERROR;
            end else begin
               update_q <= 1'b1;
               digits_q <= {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
               count_q  <= val;
               valid_q  <= 1'b1;
               state_q  <= TRACK;
               if (state_q == TRACK) begin
                  if (val == exp_v) begin
                     if (step_cnt_q != 16'hFFFF)
                        step_cnt_q <= step_cnt_q + 16'd1;
                  end else if (val == 14'd0) begin
                     clr_q <= 1'b1;
                  end else begin
                     serr_q <= 1'b1;
                  end
               end
            end
         end
      end
   end

   assign digits      = digits_q;
   assign count       = count_q;
   assign valid       = valid_q;
   assign update      = update_q;
   assign clr_seen    = clr_q;
   assign step_err    = serr_q;
   assign pattern_err = perr_q;
   assign step_cnt    = step_cnt_q;

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Randomized and directed bench for seg_decode_monitor against a
// history-based reference model of the display-acceptance rules.
module tb_seg_decode_monitor;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg_thous, seg_hunds, seg_tens, seg_units;
   logic [15:0] digits;
   logic [13:0] count;
   logic        valid, update, clr_seen, step_err, pattern_err;
   logic [15:0] step_cnt;

   seg_decode_monitor #(.STABLE_CYCLES(N)) dut (
      .clk(clk), .rst(rst),
      .seg_thous(seg_thous), .seg_hunds(seg_hunds),
      .seg_tens(seg_tens), .seg_units(seg_units),
      .digits(digits), .count(count), .valid(valid),
      .update(update), .clr_seen(clr_seen), .step_err(step_err),
      .pattern_err(pattern_err), .step_cnt(step_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // reference model state
   int          hist_len;
   logic [27:0] last_pat;
   logic [27:0] acc_pat;
   bit          seen;
   bit          tracking;
   int          m_cnt;
   logic [15:0] m_dig;
   int          m_steps;
   bit          e_upd, e_clr, e_serr, e_perr;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int segval(input logic [6:0] s);
      for (int i = 0; i < 10; i++)
         if (SEG[i] == s) return i;
      return -1;
   endfunction

   function automatic logic [27:0] mk(input int v);
      return {SEG[(v / 1000) % 10], SEG[(v / 100) % 10],
              SEG[(v / 10) % 10], SEG[v % 10]};
   endfunction

   task automatic model_reset();
      hist_len = 0;
      last_pat = '0;
      acc_pat  = '0;
      seen     = 0;
      tracking = 0;
      m_cnt    = 0;
      m_dig    = '0;
      m_steps  = 0;
      e_upd = 0; e_clr = 0; e_serr = 0; e_perr = 0;
   endtask

   task automatic model_edge();
      logic [27:0] p;
      int v [4];
      int val, expv;
      bit ok;
      p = {seg_thous, seg_hunds, seg_tens, seg_units};
      if (rst) begin
         model_reset();
         return;
      end
      if (hist_len > 0 && p == last_pat) hist_len++;
      else hist_len = 1;
      last_pat = p;
      e_upd = 0; e_clr = 0; e_serr = 0; e_perr = 0;
      if (hist_len >= N && (!seen || p != acc_pat)) begin
         acc_pat = p;
         seen = 1;
         ok = 1;
         for (int i = 0; i < 4; i++) begin
            v[i] = segval(p[27 - 7 * i -: 7]);
            if (v[i] < 0) ok = 0;
         end
         if (!ok) begin
            e_perr = 1;
            tracking = 0;
         end else begin
            val = v[0] * 1000 + v[1] * 100 + v[2] * 10 + v[3];
            e_upd = 1;
            if (tracking) begin
               expv = (m_cnt == 9999) ? 0 : m_cnt + 1;
               if (val == expv) begin
                  if (m_steps < 65535) m_steps++;
               end else if (val == 0) e_clr = 1;
               else e_serr = 1;
            end
            m_cnt = val;
            m_dig = {4'(v[0]), 4'(v[1]), 4'(v[2]), 4'(v[3])};
            tracking = 1;
         end
      end
   endtask

   task automatic compare_all(input string ph);
      check({ph, ".digits"}, 32'(digits), 32'(m_dig));
      check({ph, ".count"}, 32'(count), 32'(m_cnt));
      check({ph, ".valid"}, 32'(valid), 32'(tracking));
      check({ph, ".update"}, 32'(update), 32'(e_upd));
      check({ph, ".clr_seen"}, 32'(clr_seen), 32'(e_clr));
      check({ph, ".step_err"}, 32'(step_err), 32'(e_serr));
      check({ph, ".pattern_err"}, 32'(pattern_err), 32'(e_perr));
      check({ph, ".step_cnt"}, 32'(step_cnt), 32'(m_steps));
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(ph);
   endtask

   task automatic drive(input logic [27:0] p);
      {seg_thous, seg_hunds, seg_tens, seg_units} = p;
   endtask

   task automatic hold(input logic [27:0] p, input int n, input string ph);
      drive(p);
      for (int i = 0; i < n; i++) step(ph);
   endtask

   task automatic mid_reset(input string ph);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all({ph, ".async"});
      step(ph);
      step(ph);
      rst = 1'b0;
   endtask

   int          cur;
   int          kind;
   int          nv;
   logic [27:0] p;
   logic [6:0]  junk;

   initial begin
      model_reset();
      drive(mk(1234));
      rst = 1'b1;
      step("reset");
      step("reset");
      rst = 1'b0;

      // directed: first accept, then two +1 steps
      hold(mk(1234), 3, "d1234");
      check("d1234.count", 32'(count), 32'd1234);
      check("d1234.digits", 32'(digits), 32'h1234);
      hold(mk(1235), 3, "d1235");
      hold(mk(1236), 3, "d1236");
      check("d1236.step_cnt", 32'(step_cnt), 32'd2);

      // wrap, then an out-of-order value
      hold(mk(9999), 4, "d9999");
      hold(mk(0), 4, "dwrap");
      hold(mk(42), 3, "d0042");
      check("d0042.count", 32'(count), 32'd42);

      // zero that is not the successor, then count on from zero
      hold(mk(517), 3, "d0517");
      hold(mk(0), 3, "dclr");
      hold(mk(1), 3, "d0001");

      // undecodable tens digit, then recovery
      p = mk(1);
      p[13:7] = 7'h00;
      hold(p, 3, "dperr");
      check("dperr.valid", 32'(valid), 32'd0);
      hold(mk(3), 3, "d0003");
      check("d0003.valid", 32'(valid), 32'd1);

      // one-cycle glitch, then reset mid-hold
      hold(mk(1234), 3, "dstable");
      hold(mk(1299), 1, "dglitch");
      hold(mk(1234), 3, "dback");
      drive(mk(1235));
      mid_reset("drst");
      hold(mk(1235), 3, "dpost");

      // randomized traffic
      cur = 1235;
      for (int it = 0; it < 400; it++) begin
         kind = $urandom_range(0, 11);
         if (kind <= 5) nv = (cur + 1) % 10000;
         else if (kind == 6) nv = 0;
         else if (kind == 7) nv = 9998 + $urandom_range(0, 1);
         else nv = $urandom_range(0, 9999);
         p = mk(nv);
         if (kind == 8) begin
            junk = 7'($urandom_range(0, 127));
            p[7 * $urandom_range(0, 3) +: 7] = junk;
         end
         if (p == 28'h0) p[6:0] = 7'h3F;
         if (kind == 9) begin
            hold(p, 1, "rglitch");
         end else begin
            hold(p, $urandom_range(1, 4), "rand");
            if (kind != 8) cur = nv;
         end
         if ($urandom_range(0, 39) == 0) mid_reset("rrst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
